// File: rtl/tx.sv
// Router output stage: streams a connected input buffer, flit by flit, onto a two-phase req/ack link.
// Optional macro TX_TIMEOUT_EN adds an ack-wait timeout that aborts the packet and sets a sticky err.
module tx #(
    parameter int ID             = 0,
    parameter int SUBID          = 0,
    parameter int SIZE           = 8,
    parameter int BUFF_BITS      = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [BUFF_BITS-1:0] buf_addr_o,
    input  logic [SIZE-1:0]      buf_data_i,
    output logic                 ch_req_o,
    output logic [SIZE-1:0]      ch_flit_o,
    input  logic                 ch_ack_i,
    output logic [15:0]          sent_count_o,
    output logic                 err_o
);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;

    localparam logic [BUFF_BITS-1:0] LAST_IDX = '1;

    if (ID < 0 || SUBID < 0 || SIZE < 1 || BUFF_BITS < 1 || TIMEOUT_CYCLES < 1) begin : g_badParams
        $error("tx: illegal parameter value");
    end

    state_t               state_q, state_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [BUFF_BITS-1:0] bufAddr_q, bufAddr_d;
    logic [BUFF_BITS-1:0] flitIdx_q, flitIdx_d;
    logic                 chReq_q, chReq_d;
    logic [SIZE-1:0]      chFlit_q, chFlit_d;
    logic [15:0]          sentCount_q, sentCount_d;
    logic                 ackOld_q;
    logic                 ack;
`ifdef TX_TIMEOUT_EN
    logic [15:0]          waitCnt_q, waitCnt_d;
    logic                 err_q, err_d;
`endif

    // Acks seen outside WAIT are simply absorbed by ackOld_q tracking the line.
    assign ack = ch_ack_i ^ ackOld_q;

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        bufAddr_d   = bufAddr_q;
        flitIdx_d   = flitIdx_q;
        chReq_d     = chReq_q;
        chFlit_d    = chFlit_q;
        sentCount_d = sentCount_q;
`ifdef TX_TIMEOUT_EN
        waitCnt_d   = waitCnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    busy_d    = 1'b1;
                    flitIdx_d = '0;
                    bufAddr_d = '0;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                chFlit_d = buf_data_i;
                state_d  = SEND;
            end
            SEND: begin
                chReq_d = ~chReq_q;
`ifdef TX_TIMEOUT_EN
                waitCnt_d = '0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
                if (ack) begin
                    if (flitIdx_q == LAST_IDX) begin
                        done_d      = 1'b1;
                        busy_d      = 1'b0;
                        sentCount_d = sentCount_q + 16'd1;
                        bufAddr_d   = '0;
                        state_d     = IDLE;
                    end else begin
                        flitIdx_d = flitIdx_q + 1'b1;
                        bufAddr_d = flitIdx_q + 1'b1;
                        state_d   = LOAD;
                    end
                end
`ifdef TX_TIMEOUT_EN
                // The cycle that would bring the counter to the limit aborts the packet.
                else if (waitCnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    err_d     = 1'b1;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    bufAddr_d = '0;
                    state_d   = IDLE;
                end else begin
                    waitCnt_d = waitCnt_q + 16'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bufAddr_q   <= '0;
            flitIdx_q   <= '0;
            chReq_q     <= 1'b0;
            chFlit_q    <= '0;
            sentCount_q <= '0;
            ackOld_q    <= 1'b0;
`ifdef TX_TIMEOUT_EN
            waitCnt_q   <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            bufAddr_q   <= bufAddr_d;
            flitIdx_q   <= flitIdx_d;
            chReq_q     <= chReq_d;
            chFlit_q    <= chFlit_d;
            sentCount_q <= sentCount_d;
            ackOld_q    <= ch_ack_i;
`ifdef TX_TIMEOUT_EN
            waitCnt_q   <= waitCnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign buf_addr_o   = bufAddr_q;
    assign ch_req_o     = chReq_q;
    assign ch_flit_o    = chFlit_q;
    assign sent_count_o = sentCount_q;
`ifdef TX_TIMEOUT_EN
    assign err_o        = err_q;
`else
    assign err_o        = 1'b0;
`endif

endmodule

// File: doc/tx.md
Name: tx

Overview:
- Router output stage. Sits downstream of the switch and of each input-port receive buffer.
- When the switch connects an input port to this output, tx reads that port's packet buffer flit by flit through the buffer read interface.
- It transmits each flit on the outgoing two-phase (toggle) req/ack channel to the next router's receive stage.
- It pulses done to the switch when the last flit is acknowledged, so the switch can release the grant.

Parameters:
ID, 0, router identifier
SUBID, 0, output port index within router
SIZE, 8, flit width (bits); MSB = head-flit marker
BUFF_BITS, 3, buffer address bits; packet length FLITS = 2**BUFF_BITS
TIMEOUT_CYCLES, 255, ack-wait limit (used only with TX_TIMEOUT_EN)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start  input  1  switch request to transmit the currently connected buffer; sampled in IDLE only
busy  output  1  high from start acceptance until done
done  output  1  single-cycle pulse: packet finished (or aborted)
buf_addr  output  BUFF_BITS  read address into connected input buffer
buf_data  input  SIZE  combinational read data for buf_addr
ch_req  output  1  two-phase request; a toggle means a new flit is on ch_flit
ch_flit  output  SIZE  outgoing flit, stable from toggle until ack
ch_ack  input  1  two-phase acknowledge from downstream receiver
sent_count  output  16  number of packets completed
err  output  1  sticky timeout flag

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, buf_addr=0, ch_req=0, ch_flit=0, sent_count=0, err=0, ack_old=0, flit_idx=0.
- Ack detect: ack_old <= ch_ack every cycle; ack = ch_ack ^ ack_old. Acks arriving outside WAIT are consumed and ignored.
- States: IDLE, LOAD, SEND, WAIT.
- IDLE: on start=1, set busy<=1, flit_idx<=0, buf_addr<=0, go to LOAD. With start=0, stay in IDLE.
- LOAD: ch_flit<=buf_data (buf_addr has been stable for a full cycle); go to SEND.
- SEND: ch_req<=~ch_req; go to WAIT.
- WAIT with ack=1 and flit_idx<FLITS-1: flit_idx and buf_addr <= flit_idx+1; go to LOAD.
- WAIT with ack=1 and flit_idx==FLITS-1:
  - done<=1 for one cycle, busy<=0.
  - sent_count<=sent_count+1, wrapping 0xFFFF->0x0000.
  - buf_addr<=0; go to IDLE.
- Latency: start-sampled edge -> first ch_req toggle = 2 clocks. Each subsequent flit is toggled 2 clocks after the ack is detected. Minimum packet time = FLITS*3 clocks with zero-delay ack.
- done is never asserted together with busy=1 in the same cycle after the update. done is low in all non-completion cycles.
- start while busy: ignored; no queueing.
- start held high across done: a new packet begins on the first IDLE cycle. The switch must drop start in the same cycle it sees done if no new packet is wanted.
- ack and start in the same IDLE cycle: start is accepted, ack is discarded.
- ch_flit holds its last value in IDLE. ch_req level after a packet is arbitrary; only toggles carry meaning.
- Reset mid-packet: immediate return to IDLE with reset values. No done pulse. sent_count=0. The downstream receiver must be reset in the same event.
- Flit contents are not inspected; the head marker is passed through untouched.

Optional Feature:
- Macro TX_TIMEOUT_EN.
- Defined:
  - A 16-bit wait counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES, set err<=1 (sticky until reset), pulse done, busy<=0, and go to IDLE.
  - sent_count is not incremented on a timeout.
  - An ack arriving in the same cycle as the timeout takes priority and counts as a normal ack.
- Undefined: no counter; WAIT holds indefinitely; err tied to 0.

Test Plan:
- Reset, then start=1 for 1 cycle, buffer = 0x80,0x01..0x07, ack echoed 1 cycle after each req toggle:
  - 8 req toggles carrying 0x80,0x01,...,0x07 in order; buf_addr steps 0..7.
  - done pulses once; busy falls; sent_count=1.
- Ack delayed 10 cycles for flit 3: ch_req and ch_flit=0x03 hold stable until ack; next toggle exactly 2 clocks after ack detection.
- start pulsed again while busy at flit 4: ignored; exactly 8 flits sent; sent_count increments by 1 only.
- Spurious ack toggles in IDLE, then start: no extra flits sent; the first flit still waits for a fresh ack.
- Reset asserted at flit 5: outputs return to reset values asynchronously; no done pulse; next start sends from buf_addr=0.
- TX_TIMEOUT_EN defined, TIMEOUT_CYCLES=20, ack never returned on flit 2: err=1 and done pulses after 20 WAIT cycles; sent_count unchanged; err stays 1 across later good packets.
